// File: rtl/crossbar_pkg.sv
// Shared definitions for the crossbar arbiter and the crossbar controller:
// FSM state encoding and default sizing constants.
package crossbar_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_TIMEOUT_CYC = 64;
    localparam int TIMESTEPS       = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BUSY  = 3'd2,
        ST_ACK   = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

endpackage

// File: rtl/crossbar_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from last_ptr+1 with wraparound.
module rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] last_ptr_i,
    output logic [NUM_REQ-1:0]  onehot_o,
    output logic [ID_WIDTH-1:0] idx_o,
    output logic                any_o
);

    // Walk from the farthest offset down so the nearest set bit is written last.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int p;
            p = (int'(last_ptr_i) + k) % NUM_REQ;
            if (req_i[p]) begin
                any_o = 1'b1;
                idx_o = ID_WIDTH'(p);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign onehot_o[gi] = any_o && (idx_o == ID_WIDTH'(gi));
        end
    endgenerate

endmodule

// File: rtl/crossbar_arbiter.sv
// Round-robin arbiter sharing one crossbar integration engine between
// NUM_REQ requesters, with a watchdog that aborts hung integrations.
module crossbar_arbiter
    import crossbar_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ID_WIDTH    = 2,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int TO_WIDTH    = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  ack,
    output logic                err,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_WIDTH-1:0] gnt_id,
    output logic                busy,
    output logic                xbar_start,
    input  logic                xbar_done
);

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [ID_WIDTH-1:0] gnt_id_q, gnt_id_d;
    logic [ID_WIDTH-1:0] last_ptr_q, last_ptr_d;
    logic [TO_WIDTH-1:0] wd_q, wd_d;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [ID_WIDTH-1:0] pick_idx;
    logic                pick_any;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .req_i      (req),
        .last_ptr_i (last_ptr_q),
        .onehot_o   (pick_onehot),
        .idx_o      (pick_idx),
        .any_o      (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        last_ptr_d = last_ptr_q;
        wd_d       = wd_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d    = pick_onehot;
                    gnt_id_d = pick_idx;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                wd_d    = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                wd_d = wd_q + 1'b1;
                // Done takes precedence over a timeout landing on the same cycle.
                if (xbar_done) begin
                    state_d = ST_ACK;
                end else if (wd_q == TO_WIDTH'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_ERR;
                end
            end
            ST_ACK, ST_ERR: begin
                last_ptr_d = gnt_id_q;
                gnt_d      = '0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            last_ptr_q <= ID_WIDTH'(NUM_REQ - 1);
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            last_ptr_q <= last_ptr_d;
            wd_q       <= wd_d;
        end
    end

    // gnt_q is one-hot on the winner, so it doubles as the ack vector.
    assign ack        = (state_q == ST_ACK || state_q == ST_ERR) ? gnt_q : '0;
    assign err        = (state_q == ST_ERR);
    assign gnt        = gnt_q;
    assign gnt_id     = gnt_id_q;
    assign busy       = (state_q != ST_IDLE);
    assign xbar_start = (state_q == ST_START);

endmodule

// File: tb/tb_crossbar_arbiter.sv
// Directed self-checking bench for crossbar_arbiter (NUM_REQ=4, TIMEOUT_CYC=64).
module tb_crossbar_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] ack;
    logic       err;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       xbar_start;
    logic       xbar_done = 1'b0;

    int tests_run   = 0;
    int tests_fail  = 0;
    int ack_cnt     = 0;
    int multi_gnt   = 0;

    always #5 clk = ~clk;

    crossbar_arbiter #(
        .NUM_REQ     (4),
        .ID_WIDTH    (2),
        .TIMEOUT_CYC (64),
        .TO_WIDTH    (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ack        (ack),
        .err        (err),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .xbar_start (xbar_start),
        .xbar_done  (xbar_done)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (ack != 4'b0000) ack_cnt++;
            if (!$onehot0(gnt)) multi_gnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // done_dly >= 0: xbar_done pulsed done_dly cycles after the first BUSY cycle.
    // done_dly <  0: done never comes; ack/err expected exactly 64 cycles after BUSY entry.
    task automatic txn(input int exp_id, input int done_dly, input logic exp_err);
        int n;
        logic [3:0] oh;
        oh = 4'b0001 << exp_id;
        n = 0;
        while (!xbar_start && n < 20) begin
            step();
            n++;
        end
        check("start_seen", 32'(xbar_start), 32'd1);
        check("gnt_id", 32'(gnt_id), 32'(exp_id));
        check("gnt", 32'(gnt), 32'(oh));
        step();
        if (done_dly >= 0) begin
            repeat (done_dly) step();
            xbar_done = 1'b1;
            step();
            xbar_done = 1'b0;
        end else begin
            n = 0;
            while (ack == 4'b0000 && n < 200) begin
                step();
                n++;
            end
            check("timeout_cycles", 32'(n), 32'd64);
        end
        check("ack", 32'(ack), 32'(oh));
        check("err", 32'(err), 32'(exp_err));
        $display("[TB] txn id=%0d ack=%b err=%b", exp_id, ack, err);
    endtask

    initial begin
        int acks0;

        // Reset state
        do_reset();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(xbar_start), 32'd0);
        check("rst_gnt_id", 32'(gnt_id), 32'd0);

        // Single request, done 12 cycles after start
        req = 4'b0100;
        step();
        check("single_latency", 32'(xbar_start), 32'd1);
        txn(2, 11, 1'b0);
        req = 4'b0000;
        step();
        check("single_busy_after", 32'(busy), 32'd0);
        check("single_gnt_clear", 32'(gnt), 32'd0);
        check("single_gnt_id_hold", 32'(gnt_id), 32'd2);
        check("single_ack_once", 32'(ack), 32'd0);

        // Fairness with all requests held
        do_reset();
        acks0 = ack_cnt;
        req = 4'b1111;
        for (int t = 0; t < 8; t++) txn(t % 4, 3, 1'b0);
        req = 4'b0000;
        step();
        check("fair_ack_count", 32'(ack_cnt - acks0), 32'd8);
        check("fair_multi_gnt", 32'(multi_gnt), 32'd0);

        // Watchdog abort, then a normal transaction
        do_reset();
        req = 4'b0001;
        txn(0, -1, 1'b1);
        req = 4'b0000;
        step();
        check("wd_idle_after", 32'(busy), 32'd0);
        req = 4'b0010;
        txn(1, 5, 1'b0);
        req = 4'b0000;
        step();

        // Done coincident with the last watchdog cycle
        req = 4'b0001;
        txn(0, 63, 1'b0);
        req = 4'b0000;
        step();

        // Spurious done in IDLE, then winner drops req during BUSY
        do_reset();
        xbar_done = 1'b1;
        step();
        xbar_done = 1'b0;
        check("spur_busy", 32'(busy), 32'd0);
        check("spur_ack", 32'(ack), 32'd0);
        check("spur_start", 32'(xbar_start), 32'd0);
        req = 4'b0011;
        step();
        check("drop_start", 32'(xbar_start), 32'd1);
        check("drop_gnt_id", 32'(gnt_id), 32'd0);
        step();
        req = 4'b0010;
        repeat (2) step();
        xbar_done = 1'b1;
        step();
        xbar_done = 1'b0;
        check("drop_ack", 32'(ack), 32'd1);
        $display("[TB] txn id=0 (req dropped) ack=%b err=%b", ack, err);
        txn(1, 2, 1'b0);
        req = 4'b0000;
        step();

        // Reset during BUSY
        req = 4'b0100;
        txn_start_only();
        step();
        step();
        acks0 = ack_cnt;
        rst = 1'b1;
        req = 4'b0000;
        step();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_gnt_id", 32'(gnt_id), 32'd0);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_start", 32'(xbar_start), 32'd0);
        repeat (3) step();
        check("midrst_no_ack", 32'(ack_cnt - acks0), 32'd0);
        req = 4'b1001;
        txn(0, 2, 1'b0);
        req = 4'b0000;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

    task automatic txn_start_only();
        int n;
        n = 0;
        while (!xbar_start && n < 20) begin
            step();
            n++;
        end
        check("midrst_start_seen", 32'(xbar_start), 32'd1);
        check("midrst_pre_gnt_id", 32'(gnt_id), 32'd2);
    endtask

endmodule
